// File: rtl/ex_muldiv_unit.sv
// Iterative signed MUL/MULH/DIV/REM unit for EX, stalls the pipe while busy.
// Ports: clk_i, rst_i, start_i, op_i, data0_i, data1_i, flush_i -> busy_o, done_o, result_o.
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t          state;
  logic [1:0]      op;
  logic            sign;
  logic [W-1:0]    opnd;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;

  logic            sign_a;
  logic            sign_b;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            is_div;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [W-1:0]    special_res;
  logic            can_start;

  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_sh;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  div_next;

  logic [2*W-1:0]  prod_s;
  logic [W-1:0]    quo_s;
  logic [W-1:0]    rem_s;
  logic [W-1:0]    fix_res;

  // Operand decode and special-case detection at the accept edge.
  always_comb begin
    sign_a    = data0_i[W-1];
    sign_b    = data1_i[W-1];
    mag_a     = sign_a ? -data0_i : data0_i;
    mag_b     = sign_b ? -data1_i : data1_i;
    is_div    = op_i[1];
    div_zero  = (data1_i == '0);
    div_ovf   = (data0_i == {1'b1, {(W-1){1'b0}}}) &&
                (data1_i == '1);
    special   = is_div && (div_zero || div_ovf);
    can_start = start_i && ((state == IDLE) || (state == DONE));
    special_res = '0;
    if (op_i == OP_REM) begin
      special_res = div_zero ? data0_i : '0;
    end else begin
      special_res = div_zero ? '1 : {1'b1, {(W-1){1'b0}}};
    end
  end

  // Multiply: acc = {partial high, multiplier}; add multiplicand
  // into the high half when the current LSB is set, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[W-1:1]};
  end

  // Divide: acc = {remainder, dividend->quotient}; restoring step.
  always_comb begin
    div_sh   = {acc[2*W-1:W], acc[W-1]};
    div_diff = div_sh - {1'b0, opnd};
    if (div_diff[W]) begin
      div_next = {div_sh[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      div_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
    end
  end

  // Sign fix-up and field select.
  always_comb begin
    prod_s  = sign ? -acc : acc;
    quo_s   = sign ? -acc[W-1:0] : acc[W-1:0];
    rem_s   = sign ? -acc[2*W-1:W] : acc[2*W-1:W];
    fix_res = '0;
    unique case (op)
      OP_MUL:  fix_res = prod_s[W-1:0];
      OP_MULH: fix_res = prod_s[2*W-1:W];
      OP_DIV:  fix_res = quo_s;
      OP_REM:  fix_res = rem_s;
      default: fix_res = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      op       <= OP_MUL;
      sign     <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (can_start) begin
            op   <= op_i;
            sign <= (op_i == OP_REM) ? sign_a : (sign_a ^ sign_b);
            cnt  <= '0;
            if (special) begin
              result_o <= special_res;
              state    <= DONE;
              done_o   <= 1'b1;
              busy_o   <= 1'b0;
            end else begin
              // Divide keeps the divisor, multiply the multiplicand.
              acc    <= is_div ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
              opnd   <= is_div ? mag_b : mag_a;
              state  <= CALC;
              busy_o <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= op[1] ? div_next : mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W-1)) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          result_o <= fix_res;
          state    <= DONE;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
// Drives and samples on the falling clock edge.
module tb_ex_muldiv_unit;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data0_i;
  logic [31:0] data1_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .data0_i  (data0_i),
    .data1_i  (data1_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample index n counts falling edges after the start edge E0
  // (n=1 is the cycle after E0). lat = edges from E0 to done cycle.
  task automatic wait_done(input int n0,
                           output logic [31:0] res,
                           output int lat,
                           output int bcnt);
    res  = '0;
    lat  = -1;
    bcnt = 0;
    for (int n = n0; n <= 60; n++) begin
      if (busy_o) bcnt++;
      if (done_o) begin
        res = result_o;
        lat = n - 1;
        break;
      end
      @(negedge clk_i);
    end
    if (lat < 0) chk("timeout", {31'b0, done_o}, 32'd1);
  endtask

  // Returns at the falling edge where done_o is high.
  task automatic run_op(input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [31:0] res,
                        output int lat,
                        output int bcnt);
    start_i = 1'b1;
    op_i    = o;
    data0_i = a;
    data1_i = b;
    @(negedge clk_i);
    start_i = 1'b0;
    op_i    = o ^ 2'b01;
    data0_i = 32'hDEADBEEF;
    data1_i = 32'h12345678;
    wait_done(1, res, lat, bcnt);
  endtask

  logic [31:0] res;
  int lat;
  int bcnt;
  int seen;

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    op_i    = 2'b00;
    data0_i = '0;
    data1_i = '0;
    flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_res", result_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_op(2'b00, 32'd7, 32'hFFFFFFFD, res, lat, bcnt);
    chk("mul_res", res, 32'hFFFFFFEB);
    chk("mul_lat", lat, 32'd33);
    chk("mul_busy", bcnt, 32'd33);
    chk("mul_busy_at_done", {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);
    chk("mul_done_pulse", {31'b0, done_o}, 32'd0);
    chk("mul_hold", result_o, 32'hFFFFFFEB);

    run_op(2'b01, 32'h80000000, 32'h80000000, res, lat, bcnt);
    chk("mulh_res", res, 32'h40000000);

    run_op(2'b10, 32'hFFFFFFF9, 32'd2, res, lat, bcnt);
    chk("div_res", res, 32'hFFFFFFFD);
    chk("div_lat", lat, 32'd33);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, res, lat, bcnt);
    chk("rem_res", res, 32'hFFFFFFFF);
    run_op(2'b11, 32'd7, 32'hFFFFFFFE, res, lat, bcnt);
    chk("rem_pos", res, 32'd1);

    run_op(2'b10, 32'd5, 32'd0, res, lat, bcnt);
    chk("div0_res", res, 32'hFFFFFFFF);
    chk("div0_lat", lat, 32'd0);
    chk("div0_busy", bcnt, 32'd0);
    run_op(2'b11, 32'd5, 32'd0, res, lat, bcnt);
    chk("rem0_res", res, 32'd5);
    chk("rem0_lat", lat, 32'd0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, res, lat, bcnt);
    chk("divovf_res", res, 32'h80000000);
    chk("divovf_lat", lat, 32'd0);
    chk("divovf_busy", bcnt, 32'd0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, res, lat, bcnt);
    chk("removf_res", res, 32'd0);
    chk("removf_lat", lat, 32'd0);

    run_op(2'b00, 32'd7, 32'd6, res, lat, bcnt);
    chk("mul42", res, 32'd42);
    @(negedge clk_i);

    // Flush at iteration 10 of DIV 100/7.
    start_i = 1'b1;
    op_i    = 2'b10;
    data0_i = 32'd100;
    data1_i = 32'd7;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    chk("pre_flush_busy", {31'b0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy", {31'b0, busy_o}, 32'd0);
    chk("flush_done", {31'b0, done_o}, 32'd0);
    chk("flush_res", result_o, 32'd42);
    seen = 0;
    repeat (40) begin
      if (done_o || busy_o) seen++;
      @(negedge clk_i);
    end
    chk("flush_quiet", seen, 32'd0);

    // Start and flush together: start dropped.
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 2'b00;
    data0_i = 32'd2;
    data1_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    flush_i = 1'b0;
    seen = 0;
    repeat (40) begin
      if (done_o || busy_o) seen++;
      @(negedge clk_i);
    end
    chk("sflush_quiet", seen, 32'd0);
    chk("sflush_res", result_o, 32'd42);

    // Start while busy is ignored.
    start_i = 1'b1;
    op_i    = 2'b00;
    data0_i = 32'd6;
    data1_i = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 2'b10;
    data0_i = 32'd100;
    data1_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(6, res, lat, bcnt);
    chk("busy_start_res", res, 32'd54);
    chk("busy_start_lat", lat, 32'd33);

    // Back-to-back: second start in the done cycle.
    run_op(2'b00, 32'd9, 32'd9, res, lat, bcnt);
    chk("b2b_first", res, 32'd81);
    run_op(2'b00, 32'hFFFFFFFE, 32'd5, res, lat, bcnt);
    chk("b2b_second", res, 32'hFFFFFFF6);
    chk("b2b_lat", lat, 32'd33);
    @(negedge clk_i);

    // Asynchronous reset mid-CALC, between edges.
    start_i = 1'b1;
    op_i    = 2'b00;
    data0_i = 32'd5;
    data1_i = 32'd6;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy_o}, 32'd0);
    chk("arst_done", {31'b0, done_o}, 32'd0);
    chk("arst_res", result_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    run_op(2'b00, 32'd3, 32'd4, res, lat, bcnt);
    chk("post_rst_mul", res, 32'h0000000C);
    chk("post_rst_lat", lat, 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Takes the same two 32-bit operands as the ALU and runs signed MUL/MULH/DIV/REM over multiple cycles.
- Holds the pipeline while it works.
- Its registered result is muxed with the ALU output before the EX/MEM register. This moves the single-cycle 32x32 multiply off the ALU critical path.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE or DONE.
- op_i  input  2  00 MUL (low word), 01 MULH (signed high word), 10 DIV (signed quotient), 11 REM (signed remainder).
- data0_i  input  DATA_WIDTH  operand A / dividend; captured on accepted start.
- data1_i  input  DATA_WIDTH  operand B / divisor; captured on accepted start.
- flush_i  input  1  aborts any operation; returns to IDLE.
- busy_o  output  1  high in CALC and FIX; drives the pipeline stall.
- done_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  DATA_WIDTH  registered result; held until the next accepted start, flush or reset.

Behaviour:
Reset:
- Any time rst_i=1: state=IDLE, busy_o=0, done_o=0, result_o=0, counter=0, internal accumulators=0.
- Reset mid-operation discards everything; there is no partial result.

States:
- IDLE, CALC, FIX, DONE. Start is accepted in IDLE or DONE.

Accepted start (edge E0):
- Latch op_i, the operand magnitudes and the result sign.
  - MUL/MULH sign = signA^signB.
  - DIV sign = signA^signB.
  - REM sign = signA.
- Special cases go directly to DONE with the result loaded at E0:
  - DIV by 0 -> all ones (0xFFFFFFFF).
  - REM by 0 -> data0_i.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
  - These complete with done_o=1 in the cycle after E0 and busy_o never asserted.
- Otherwise: go to CALC, counter=0.

CALC, one iteration per edge (E1..E32):
- Multiply: unsigned shift-add on magnitudes into a 2*DATA_WIDTH product.
- Divide: unsigned restoring step; shift remainder left, subtract divisor, keep if non-negative, shift quotient bit in.
- After counter reaches DATA_WIDTH-1 -> FIX.

FIX, one edge (E33):
- Apply the sign (two's complement negate if sign=1).
- Select the field: MUL product[31:0], MULH product[63:32], DIV quotient, REM remainder.
- Load result_o; go to DONE.

DONE:
- done_o=1 for exactly one cycle (the cycle after E33); result_o valid from that cycle on.
- The next edge returns to IDLE, or to CALC/special-case handling if start_i=1.

Latency and stall:
- Normal op: done_o 33 cycles after the start edge.
- busy_o=1 from the cycle after E0 through the cycle after E32 (33 cycles); busy_o=0 in the done_o cycle.

Handshake and boundary rules:
- start_i while busy_o=1 is ignored.
- Operand/op changes after acceptance have no effect.
- flush_i=1 at any edge: state=IDLE, busy_o=0, done_o=0, result_o unchanged.
- flush_i and start_i together: flush wins; the start is dropped.
- Back-to-back: start_i=1 in the done_o cycle is accepted; done_o still pulses for the first op.
- Arithmetic is modulo 2^DATA_WIDTH; no overflow flag.

Test Plan:
- Reset mid-CALC (rst_i pulsed between edges, not edge-aligned) -> outputs 0 immediately, state IDLE; a new MUL 3*4 then gives 0x0000000C.
- MUL 7 * 0xFFFFFFFD -> result_o=0xFFFFFFEB, done_o exactly 33 cycles after start, busy_o high 33 cycles; MULH 0x80000000*0x80000000 -> 0x40000000.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; REM 7 / 0xFFFFFFFE -> 1.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
  - Each gives done_o one cycle after start with busy_o never high.
- flush_i at iteration 10 of DIV 100/7 -> busy_o=0 next cycle, no done_o, result_o keeps its old value; a start+flush in the same cycle is dropped.
- Start during busy with different operands is ignored (result matches the first op); back-to-back start in the done_o cycle -> second result 33 cycles later.
